press_classifier: RTL and testbench
===================================

// Module: press_classifier
// PURPOSE
//   Consumes one debounced switch level (the debouncer "state" output, 1 = pressed).
//   Classifies each gesture as a short press, a long press or a double press.
//   Emits one-cycle event pulses to the LED/control logic downstream.
//   Purely synchronous to CLK. The input is already clean, so there is no synchroniser.
// PARAMETERS
//   LONG_TICKS    50_000_000  cycles held before a press counts as long (1 s @ 50 MHz)
//   DOUBLE_TICKS  12_500_000  max cycles from release to second press for a double press
//   REPEAT_TICKS   5_000_000  auto-repeat period while long-held (AUTO_REPEAT_EN only)
//   CNT_W         26          counter width; 2**CNT_W > max(LONG_TICKS, DOUBLE_TICKS, REPEAT_TICKS)
// PORTS
//   CLK           in   1  system clock, all logic on posedge
//   RST           in   1  asynchronous, active-high reset
//   press         in   1  debounced switch level, 1 = pressed
//   short_pulse   out  1  one-cycle pulse: short press confirmed
//   long_pulse    out  1  one-cycle pulse: long-press threshold reached
//   double_pulse  out  1  one-cycle pulse: double press completed
//   repeat_pulse  out  1  one-cycle pulse: auto-repeat tick (0 when feature compiled out)
//   held          out  1  level: 1 while in LONG state
// BEHAVIOUR
//   Reset (async, RST=1):
//     - state=IDLE, cnt=0, every output 0.
//     - press_q=1, so a switch already held at reset exit is ignored until it is released.
//   Edge detect: rise = press & ~press_q. press_q is a register of press.
//   Timing counter:
//     - Zeroed on every state change; otherwise increments by 1 per cycle.
//     - Saturates at all-ones and never wraps.
//   Clock-edge numbering: edge 0 is the first posedge that samples rise=1.
//   States and transitions:
//     - IDLE:   rise -> PRESS1.
//     - PRESS1: press=0 -> WAIT2.
//               press=1 && cnt==LONG_TICKS-1 -> LONG; long_pulse=1 for one cycle.
//     - WAIT2:  rise -> PRESS2.
//               otherwise, cnt==DOUBLE_TICKS-1 -> IDLE; short_pulse=1.
//               Simultaneous rise and timeout: rise wins, giving PRESS2 and no short_pulse.
//     - PRESS2: press=0 -> IDLE; double_pulse=1.
//               press=1 && cnt==LONG_TICKS-1 -> LONG; long_pulse=1. The double press is discarded.
//     - LONG:   held=1. press=0 -> IDLE with no pulse.
//   Pulse timing:
//     - All pulses are registered and assert in the cycle after the deciding edge.
//     - At most one pulse per cycle; the pulses are mutually exclusive.
//   Latency:
//     - long_pulse: high for the cycle after edge LONG_TICKS.
//     - short_pulse: high DOUBLE_TICKS+1 cycles after release is sampled.
//   Reset mid-gesture: the pending event is dropped and no pulse is emitted.
// CONFIGURATION
//   Macro AUTO_REPEAT_EN.
//   Defined:
//     - In LONG, a second counter emits repeat_pulse every REPEAT_TICKS cycles.
//     - The first repeat_pulse is REPEAT_TICKS cycles after long_pulse.
//     - The repeat counter is cleared on leaving LONG and on reset.
//   Undefined:
//     - The repeat counter is not built.
//     - repeat_pulse is tied to 0.
//     - The port list is unchanged.
// TESTING  (bench params: LONG_TICKS=20, DOUBLE_TICKS=8, REPEAT_TICKS=5, CNT_W=8)
//   1. Short press: press=1 for 5 cycles, then 0.
//      -> exactly one short_pulse, 9 cycles after release is sampled; no other pulses.
//   2. Long press: press=1 for 40 cycles.
//      -> long_pulse once, in the cycle after edge 20; held=1 until release; no pulse on release.
//   3. Double press: press 3 on, 3 off, 3 on, then off.
//      -> one double_pulse, 1 cycle after the second release; no short_pulse.
//   4. Boundary: second rise sampled on the same edge as the WAIT2 timeout (cnt==7).
//      -> PRESS2, and no short_pulse.
//      Second rise 1 cycle later -> short_pulse, then a new PRESS1.
//   5. Reset: press held through RST deassert -> no pulses until release and a fresh press.
//      RST pulsed mid-PRESS1 -> outputs 0 immediately; no pulse follows.
//   6. AUTO_REPEAT_EN, press held 40 cycles:
//      -> repeat_pulse at 5, 10, 15 cycles after long_pulse.
//      Without the macro, repeat_pulse stays 0.

Source files
------------

// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - short/long/double press classifier; optional auto-repeat via AUTO_REPEAT_EN
module press_classifier #(
  parameter int LONG_TICKS   = 50_000_000,
  parameter int DOUBLE_TICKS = 12_500_000,
  parameter int REPEAT_TICKS = 5_000_000,
  parameter int CNT_W        = 26
) (
  input  logic CLK,
  input  logic RST,
  input  logic press,
  output logic short_pulse,
  output logic long_pulse,
  output logic double_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_LONG   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press_q;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  logic             r_held;
  logic             w_rise;

  assign w_rise = press & ~r_press_q;

  // Previous press level; resets high so a switch held through reset is not seen as a new press
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_press_q <= 1'b1;
    end else begin
      r_press_q <= press;
    end
  end

  // Gesture FSM with its timing counter and registered event outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      // Pulses last one cycle; the counter free-runs and saturates unless a transition zeroes it
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_PRESS1;
            r_cnt   <= '0;
          end
        end
        S_PRESS1: begin
          // A release on the threshold edge still counts as a release
          if (!press) begin
            r_state <= S_WAIT2;
            r_cnt   <= '0;
          end else if (r_cnt == LONG_LAST) begin
            r_state <= S_LONG;
            r_cnt   <= '0;
            r_long  <= 1'b1;
            r_held  <= 1'b1;
          end
        end
        S_WAIT2: begin
          // A second press on the timeout edge wins over the short-press decision
          if (w_rise) begin
            r_state <= S_PRESS2;
            r_cnt   <= '0;
          end else if (r_cnt == DOUBLE_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_short <= 1'b1;
          end
        end
        S_PRESS2: begin
          if (!press) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_double <= 1'b1;
          end else if (r_cnt == LONG_LAST) begin
            r_state <= S_LONG;
            r_cnt   <= '0;
            r_long  <= 1'b1;
            r_held  <= 1'b1;
          end
        end
        S_LONG: begin
          if (!press) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign short_pulse  = r_short;
  assign long_pulse   = r_long;
  assign double_pulse = r_double;
  assign held         = r_held;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_repeat;

  // Auto-repeat divider; runs only while the long press is still held, idle and cleared otherwise
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rep_cnt <= '0;
      r_repeat  <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      if (r_state == S_LONG && press) begin
        if (r_rep_cnt == REPEAT_LAST) begin
          r_rep_cnt <= '0;
          r_repeat  <= 1'b1;
        end else begin
          r_rep_cnt <= r_rep_cnt + CNT_ONE;
        end
      end else begin
        r_rep_cnt <= '0;
      end
    end
  end

  assign repeat_pulse = r_repeat;
`else
  logic w_unused_repeat;

  assign w_unused_repeat = (REPEAT_TICKS != 0);
  assign repeat_pulse    = 1'b0;
`endif

endmodule

// File: tb/tb_press_classifier.sv
// tb/tb_press_classifier.sv - self-checking bench for press_classifier against a gesture-timeline model
`timescale 1ns/1ps
module tb_press_classifier;

  localparam int LT   = 20;
  localparam int DT   = 8;
  localparam int RT   = 5;
  localparam int CW   = 8;
  localparam int MAXN = 512;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic press = 1'b0;
  logic short_pulse;
  logic long_pulse;
  logic double_pulse;
  logic repeat_pulse;
  logic held;

  int checks = 0;
  int errors = 0;

  // wave[t] is the press level sampled on edge t after reset release
  bit wave[$];
  bit e_short [MAXN];
  bit e_long  [MAXN];
  bit e_double[MAXN];
  bit e_rep   [MAXN];
  bit e_held  [MAXN];

  press_classifier #(
    .LONG_TICKS  (LT),
    .DOUBLE_TICKS(DT),
    .REPEAT_TICKS(RT),
    .CNT_W       (CW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .press       (press),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .double_pulse(double_pulse),
    .repeat_pulse(repeat_pulse),
    .held        (held)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int t, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed %0b expected %0b", tag, t, obs, exp);
    end
  endtask

  task automatic add(input bit v, input int len);
    for (int i = 0; i < len; i++) wave.push_back(v);
  endtask

  // A level held through reset is not a press: the first edge never counts as a rise
  function automatic bit is_rise(input int t);
    if (t == 0) return 1'b0;
    return wave[t] && !wave[t-1];
  endfunction

  function automatic int next_rise(input int from);
    for (int t = from; t < wave.size(); t++) if (is_rise(t)) return t;
    return wave.size();
  endfunction

  function automatic int next_fall(input int from);
    for (int t = from; t < wave.size(); t++) if (!wave[t]) return t;
    return wave.size();
  endfunction

  // Press rising at edge s and released at edge f, long enough to become a long press
  function automatic void mark_long(input int s, input int f);
    int n;
    n = wave.size();
    if (s + LT < n) e_long[s+LT] = 1'b1;
    for (int t = s + LT; t < f && t < n; t++) e_held[t] = 1'b1;
`ifdef AUTO_REPEAT_EN
    for (int t = s + LT + RT; t < f && t < n; t += RT) e_rep[t] = 1'b1;
`endif
  endfunction

  // Walk the waveform gesture by gesture and place each expected event on its deciding edge
  function automatic void build_model();
    int n, t, s, f, r2, f2;
    n = wave.size();
    for (int i = 0; i < MAXN; i++) begin
      e_short[i] = 1'b0; e_long[i] = 1'b0; e_double[i] = 1'b0;
      e_rep[i] = 1'b0; e_held[i] = 1'b0;
    end
    t = next_rise(0);
    while (t < n) begin
      s = t;
      f = next_fall(s + 1);
      if (f > s + LT) begin
        mark_long(s, f);
        t = next_rise(f + 1);
      end else begin
        r2 = next_rise(f + 1);
        if (r2 > f + DT) begin
          if (f + DT < n) e_short[f+DT] = 1'b1;
          t = next_rise(f + DT + 1);
        end else begin
          f2 = next_fall(r2 + 1);
          if (f2 > r2 + LT) mark_long(r2, f2);
          else if (f2 < n) e_double[f2] = 1'b1;
          t = next_rise(f2 + 1);
        end
      end
    end
  endfunction

  // Reset (asynchronously, mid-cycle) then play the waveform and compare every cycle
  task automatic run_wave(input string name);
    int n;
    n = wave.size();
    build_model();
    @(negedge CLK);
    #2;
    press = wave[0];
    RST = 1'b1;
    #1;
    chk({name, "/rst_short"},  -1, short_pulse,  1'b0);
    chk({name, "/rst_long"},   -1, long_pulse,   1'b0);
    chk({name, "/rst_double"}, -1, double_pulse, 1'b0);
    chk({name, "/rst_repeat"}, -1, repeat_pulse, 1'b0);
    chk({name, "/rst_held"},   -1, held,         1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int t = 0; t < n; t++) begin
      press = wave[t];
      @(posedge CLK);
      #1;
      chk({name, "/short"},  t, short_pulse,  e_short[t]);
      chk({name, "/long"},   t, long_pulse,   e_long[t]);
      chk({name, "/double"}, t, double_pulse, e_double[t]);
      chk({name, "/repeat"}, t, repeat_pulse, e_rep[t]);
      chk({name, "/held"},   t, held,         e_held[t]);
      @(negedge CLK);
    end
  endtask

  initial begin
    bit v;

    // Short press
    wave.delete(); add(0, 3); add(1, 5); add(0, 30);
    run_wave("short");

    // Long press held 40 cycles (repeats when auto-repeat is built)
    wave.delete(); add(0, 2); add(1, 40); add(0, 10);
    run_wave("long");

    // Double press
    wave.delete(); add(0, 2); add(1, 3); add(0, 3); add(1, 3); add(0, 15);
    run_wave("double");

    // Second rise on the very edge of the double-press timeout
    wave.delete(); add(0, 2); add(1, 3); add(0, DT); add(1, 3); add(0, 20);
    run_wave("edge_rise");

    // Second rise one edge too late: short, then a fresh gesture
    wave.delete(); add(0, 2); add(1, 3); add(0, DT + 1); add(1, 3); add(0, 20);
    run_wave("late_rise");

    // Press already held when reset is released
    wave.delete(); add(1, 10); add(0, 5); add(1, 3); add(0, 20);
    run_wave("held_reset");

    // Leave the design mid-PRESS1, then reset with the switch still down
    wave.delete(); add(0, 2); add(1, 10);
    run_wave("pre_press1");
    wave.delete(); add(1, 6); add(0, 25);
    run_wave("rst_press1");

    // Leave the design in LONG so the next reset must clear held at once
    wave.delete(); add(0, 2); add(1, 30);
    run_wave("pre_long");
    wave.delete(); add(0, 30);
    run_wave("rst_long");

    // Randomized gesture sequences
    for (int r = 0; r < 8; r++) begin
      wave.delete();
      v = 1'($urandom_range(0, 1));
      while (wave.size() < 220) begin
        add(v, int'($urandom_range(1, (r % 2) ? 12 : 45)));
        v = !v;
      end
      run_wave("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
